// File: rtl/cpu_pkg.sv
// Shared CPU definitions: scoreboard entry layout and default widths for the
// forwarding/hazard unit.
package cpu_pkg;

    localparam int DATA_W_DEF = 32'sd32;
    localparam int REG_AW_DEF = 32'sd5;
    localparam int REG_AW_MAX = 32'sd8;
    localparam int FWD_SEL_RF = 32'sd0;

    // dest is stored at the widest supported address width so one entry type serves every REG_AW
    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] dest;
        logic                  is_load;
    } sb_entry_t;

endpackage

// File: rtl/forwarding_scoreboard_if.sv
// Issue/operand bundle between the DOF stage (master) and the forwarding
// scoreboard (slave).
interface forwarding_scoreboard_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = 32'sd3
);
    localparam int SEL_W = $clog2(DEPTH + 32'sd1);

    logic                    issue_valid;
    logic                    issue_we;
    logic                    issue_is_load;
    logic [REG_AW-1:0]       issue_dest;
    logic [REG_AW-1:0]       src_a;
    logic [REG_AW-1:0]       src_b;
    logic                    use_a;
    logic                    use_b;
    logic                    flush;
    logic [DATA_W-1:0]       rf_data_a;
    logic [DATA_W-1:0]       rf_data_b;
    logic [DEPTH*DATA_W-1:0] stage_data;
    logic [DATA_W-1:0]       fwd_data_a;
    logic [DATA_W-1:0]       fwd_data_b;
    logic [SEL_W-1:0]        fwd_sel_a;
    logic [SEL_W-1:0]        fwd_sel_b;
    logic                    stall;
    logic [15:0]             stall_cnt;

    modport master (
        output issue_valid, issue_we, issue_is_load, issue_dest,
        output src_a, src_b, use_a, use_b, flush,
        output rf_data_a, rf_data_b, stage_data,
        input  fwd_data_a, fwd_data_b, fwd_sel_a, fwd_sel_b, stall, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_we, issue_is_load, issue_dest,
        input  src_a, src_b, use_a, use_b, flush,
        input  rf_data_a, rf_data_b, stage_data,
        output fwd_data_a, fwd_data_b, fwd_sel_a, fwd_sel_b, stall, stall_cnt
    );

endinterface

// File: rtl/fwd_operand_sel.sv
// Per-operand forwarding select: finds the youngest in-flight producer of src,
// muxes its stage result and flags a stall when that result is not ready yet.
module fwd_operand_sel
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int DEPTH    = 32'sd3,
    parameter int LOAD_LAT = 32'sd2,
    parameter int SEL_W    = $clog2(DEPTH + 32'sd1)
) (
    input  sb_entry_t [DEPTH:1]      sb,
    input  logic [REG_AW-1:0]        src,
    input  logic                     use_src,
    input  logic [DATA_W-1:0]        rf_data,
    input  logic [DEPTH*DATA_W-1:0]  stage_data,
    output logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        data,
    output logic                     need_stall
);

    logic found_s;

    // Priority encoder from stage 1 upward; an older ready producer never overrides a younger unready one
    always_comb begin
        sel        = SEL_W'(FWD_SEL_RF);
        data       = rf_data;
        need_stall = 1'b0;
        found_s    = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!found_s && sb[k].valid && (sb[k].dest == REG_AW_MAX'(src)) &&
                (src != '0) && use_src) begin
                found_s    = 1'b1;
                sel        = SEL_W'(k);
                data       = stage_data[k*DATA_W-1 -: DATA_W];
                need_stall = sb[k].is_load && (k < LOAD_LAT);
            end else begin
                found_s    = found_s;
            end
        end
    end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Operand forwarding and load-use hazard unit with a DEPTH-entry shift scoreboard.
// Optional stall-cycle counter enabled by defining FWD_PERF_CNT_EN.
module forwarding_scoreboard
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int DEPTH    = 32'sd3,
    parameter int LOAD_LAT = 32'sd2
) (
    input  logic                  clk,
    input  logic                  rst,
    forwarding_scoreboard_if.slave bus
);

    localparam int SEL_W = $clog2(DEPTH + 32'sd1);

    sb_entry_t [DEPTH:1] sb_r;
    sb_entry_t           ins_s;
    logic                need_a_s;
    logic                need_b_s;
    logic                stall_s;

    fwd_operand_sel #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
    ) u_sel_a (
        .sb(sb_r), .src(bus.src_a), .use_src(bus.use_a), .rf_data(bus.rf_data_a),
        .stage_data(bus.stage_data), .sel(bus.fwd_sel_a), .data(bus.fwd_data_a),
        .need_stall(need_a_s)
    );

    fwd_operand_sel #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
    ) u_sel_b (
        .sb(sb_r), .src(bus.src_b), .use_src(bus.use_b), .rf_data(bus.rf_data_b),
        .stage_data(bus.stage_data), .sel(bus.fwd_sel_b), .data(bus.fwd_data_b),
        .need_stall(need_b_s)
    );

    // Flush overrides stall so a squashed instruction can never hold the front end
    always_comb begin
        if (bus.issue_valid && !bus.flush) begin
            stall_s = need_a_s || need_b_s;
        end else begin
            stall_s = 1'b0;
        end
    end

    assign bus.stall = stall_s;

    // Entry 1 gets the issuing writer, or a bubble when it is stalled, flushed or writes R0
    always_comb begin
        ins_s = '0;
        if (bus.issue_valid && bus.issue_we && (bus.issue_dest != '0) && !stall_s && !bus.flush) begin
            ins_s.valid   = 1'b1;
            ins_s.dest    = REG_AW_MAX'(bus.issue_dest);
            ins_s.is_load = bus.issue_is_load;
        end else begin
            ins_s = '0;
        end
    end

    // Scoreboard always shifts; downstream stages advance even while DOF is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_r <= '0;
        end else begin
            sb_r[1] <= ins_s;
            for (int k = 2; k <= DEPTH; k++) begin
                sb_r[k] <= sb_r[k-1];
            end
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of stalled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.stall_cnt = stall_cnt_r;
`else
    assign bus.stall_cnt = 16'h0000;
`endif

endmodule
